// File: rtl/calc_operand_entry.sv
// Button-driven operand/operator entry FSM for the 4-bit calculator; latches the result and muxes the display.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the Up/Down buttons.
module calc_operand_entry #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btnUp,
  input  logic       i_btnDown,
  input  logic       i_btnNext,
  input  logic [3:0] i_result,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [1:0] o_selOperator,
  output logic [1:0] o_state,
  output logic [3:0] o_display,
  output logic       o_resultValid
);

  typedef enum logic [1:0] {
    EDIT_A      = 2'b00,
    EDIT_B      = 2'b01,
    EDIT_OP     = 2'b10,
    SHOW_RESULT = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [3:0] res_q, res_d;
  logic       up_prev_q, down_prev_q, next_prev_q;

  logic up_ev, down_ev, next_ev;
  logic step_up, step_down;

  assign up_ev   = i_btnUp   & ~up_prev_q;
  assign down_ev = i_btnDown & ~down_prev_q;
  assign next_ev = i_btnNext & ~next_prev_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rep_phase_q, rep_phase_d;
  logic          hold, rep_fire;

  // A held Next never advances state, so holding only in EDIT states with Next low
  // already implies the counter restarts whenever the state changes.
  assign hold     = (i_btnUp ^ i_btnDown) & ~i_btnNext & (state_q != SHOW_RESULT);
  assign rep_fire = hold &&
                    (hold_cnt_q == (rep_phase_q ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY)));

  always_comb begin
    hold_cnt_d  = '0;
    rep_phase_d = 1'b0;
    if (hold) begin
      if (rep_fire) begin
        hold_cnt_d  = CW'(1);
        rep_phase_d = 1'b1;
      end else begin
        hold_cnt_d  = hold_cnt_q + CW'(1);
        rep_phase_d = rep_phase_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  assign step_up   = (up_ev & ~down_ev) | (rep_fire & i_btnUp);
  assign step_down = (down_ev & ~up_ev) | (rep_fire & i_btnDown);
`else
  assign step_up   = up_ev & ~down_ev;
  assign step_down = down_ev & ~up_ev;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    if (next_ev) begin
      unique case (state_q)
        EDIT_A:      state_d = EDIT_B;
        EDIT_B:      state_d = EDIT_OP;
        EDIT_OP: begin
          state_d = SHOW_RESULT;
          res_d   = i_result;
        end
        SHOW_RESULT: state_d = EDIT_A;
        default:     state_d = EDIT_A;
      endcase
    end else if (step_up || step_down) begin
      unique case (state_q)
        EDIT_A:  a_d  = step_up ? a_q + 4'd1 : a_q - 4'd1;
        EDIT_B:  b_d  = step_up ? b_q + 4'd1 : b_q - 4'd1;
        EDIT_OP: op_d = step_up ? op_q + 2'd1 : op_q - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_reset) begin
      state_q     <= EDIT_A;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      op_q        <= 2'd0;
      res_q       <= 4'd0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      next_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      up_prev_q   <= i_btnUp;
      down_prev_q <= i_btnDown;
      next_prev_q <= i_btnNext;
    end
  end

  assign o_a           = a_q;
  assign o_b           = b_q;
  assign o_selOperator = op_q;
  assign o_state       = state_q;
  assign o_resultValid = (state_q == SHOW_RESULT);

  always_comb begin
    unique case (state_q)
      EDIT_A:      o_display = a_q;
      EDIT_B:      o_display = b_q;
      EDIT_OP:     o_display = {2'b00, op_q};
      SHOW_RESULT: o_display = res_q;
      default:     o_display = 4'd0;
    endcase
  end

endmodule
